// File: rtl/pll_reconfig_seq_if.sv
// Configuration, reconfig-IP and PLL signals of the reconfiguration sequencer.
// master: config source plus reconfig IP / PLL side; slave: the sequencer itself.
interface pll_reconfig_seq_if #(
  parameter int NUM_CNT = 2,
  parameter int DATA_W  = 9
);
  logic                      cfg_valid;
  logic                      cfg_ready;
  logic [NUM_CNT-1:0]        cfg_en_mask;
  logic [NUM_CNT*DATA_W-1:0] cfg_data;
  logic                      cfg_sync;
  logic                      rcfg_busy;
  logic                      rcfg_write_param;
  logic [3:0]                rcfg_counter_type;
  logic [2:0]                rcfg_counter_param;
  logic [DATA_W-1:0]         rcfg_data_in;
  logic                      rcfg_reconfig;
  logic                      pll_locked;
  logic                      pll_areset;
  logic                      done;
  logic                      error;
  logic [3:0]                state_test;

  modport master (
    output cfg_valid, cfg_en_mask, cfg_data, cfg_sync, rcfg_busy, pll_locked,
    input  cfg_ready, rcfg_write_param, rcfg_counter_type, rcfg_counter_param,
           rcfg_data_in, rcfg_reconfig, pll_areset, done, error, state_test
  );

  modport slave (
    input  cfg_valid, cfg_en_mask, cfg_data, cfg_sync, rcfg_busy, pll_locked,
    output cfg_ready, rcfg_write_param, rcfg_counter_type, rcfg_counter_param,
           rcfg_data_in, rcfg_reconfig, pll_areset, done, error, state_test
  );
endinterface

// File: rtl/pll_reconfig_seq.sv
// PLL reconfiguration sequencer: latches a counter config, waits for a delayed sync, writes the
// selected counters, triggers reconfig and supervises lock with bounded areset retries.
module pll_reconfig_seq #(
  parameter int NUM_CNT       = 2,
  parameter int DATA_W        = 9,
  parameter int CNT_TYPE_BASE = 4,
  parameter int CNT_PARAM     = 2,
  parameter int SYNC_DLY      = 16,
  parameter int LOCK_TIMEOUT  = 1024,
  parameter int MAX_RETRY     = 3,
  parameter int ARST_W        = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  pll_reconfig_seq_if.slave bus
);
  localparam int TMAX0 = (LOCK_TIMEOUT > SYNC_DLY) ? LOCK_TIMEOUT : SYNC_DLY;
  localparam int TMAX  = (TMAX0 > ARST_W) ? TMAX0 : ARST_W;
  localparam int TMR_W = $clog2(TMAX + 1);
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int IDX_W = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;

  typedef enum logic [3:0] {
    IDLE = 4'd0, ARMED = 4'd1, SYNC_WAIT = 4'd2, WRITE = 4'd3, WAIT_WR = 4'd4,
    RECONF = 4'd5, WAIT_RC = 4'd6, WAIT_LOCK = 4'd7, AREST = 4'd8, DONE = 4'd9
  } state_t;

  state_t                    state, state_nx;
  logic [1:0]                sync_ff, lock_ff;
  logic                      sync_d;
  logic [TMR_W-1:0]          timer;
  logic [RTY_W-1:0]          retry;
  logic [2:0]                lock_cnt;
  logic                      error_q;
  logic [NUM_CNT-1:0]        mask_q;
  logic [NUM_CNT*DATA_W-1:0] data_q;
  logic [IDX_W-1:0]          cur_idx, first_idx, next_idx;
  logic                      has_next, sync_rise, cfg_load, cfg_ready;
  logic                      write_param, reconfig, areset, done_o;
  logic [3:0]                counter_type;
  logic [DATA_W-1:0]         data_in;

  assign sync_rise = sync_ff[1] & ~sync_d;
  assign cfg_ready = (state == IDLE) || (state == ARMED);
  assign cfg_load  = bus.cfg_valid && cfg_ready && (|bus.cfg_en_mask);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sync_ff <= '0;
      lock_ff <= '0;
      sync_d  <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[0], bus.cfg_sync};
      lock_ff <= {lock_ff[0], bus.pll_locked};
      sync_d  <= sync_ff[1];
    end
  end

  // Lowest set mask bit starts the sequence; the next higher set bit follows each write.
  always_comb begin
    first_idx = '0;
    next_idx  = '0;
    has_next  = 1'b0;
    for (int i = NUM_CNT - 1; i >= 0; i--) begin
      if (mask_q[i]) first_idx = IDX_W'(i);
      if (mask_q[i] && (i > int'(cur_idx))) begin
        has_next = 1'b1;
        next_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (cfg_load) state_nx = ARMED;
      ARMED:     if (sync_rise) state_nx = SYNC_WAIT;
      SYNC_WAIT: if (timer == TMR_W'(SYNC_DLY - 1)) state_nx = WRITE;
      WRITE:     if (timer == TMR_W'(1)) state_nx = WAIT_WR;
      WAIT_WR:   if (!bus.rcfg_busy) state_nx = has_next ? WRITE : RECONF;
      RECONF:    if (timer == TMR_W'(1)) state_nx = WAIT_RC;
      WAIT_RC:   if (!bus.rcfg_busy) state_nx = WAIT_LOCK;
      WAIT_LOCK: begin
        if (lock_ff[1] && (lock_cnt == 3'd7))
          state_nx = DONE;
        else if (timer == TMR_W'(LOCK_TIMEOUT - 1))
          state_nx = (retry < RTY_W'(MAX_RETRY)) ? AREST : IDLE;
      end
      AREST:     if (timer == TMR_W'(ARST_W - 1)) state_nx = WAIT_LOCK;
      DONE:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Timer restarts on every state change, so each timed state starts from zero.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      timer    <= '0;
      retry    <= '0;
      lock_cnt <= '0;
      error_q  <= 1'b0;
      mask_q   <= '0;
      data_q   <= '0;
      cur_idx  <= '0;
    end else begin
      if (state_nx != state)         timer <= '0;
      else if (timer != TMR_W'(TMAX)) timer <= timer + TMR_W'(1);

      if ((state == WAIT_LOCK) && lock_ff[1]) lock_cnt <= lock_cnt + 3'd1;
      else                                    lock_cnt <= '0;

      if (cfg_load) begin
        mask_q  <= bus.cfg_en_mask;
        data_q  <= bus.cfg_data;
        error_q <= 1'b0;
        retry   <= '0;
      end
      if ((state == WAIT_LOCK) && (state_nx == AREST)) retry <= retry + RTY_W'(1);
      if ((state == WAIT_LOCK) && (state_nx == IDLE))  error_q <= 1'b1;
      if (state == DONE)                               retry <= '0;

      if ((state == SYNC_WAIT) && (state_nx == WRITE))    cur_idx <= first_idx;
      else if ((state == WAIT_WR) && (state_nx == WRITE)) cur_idx <= next_idx;
    end
  end

  always_comb begin
    write_param  = 1'b0;
    reconfig     = 1'b0;
    areset       = 1'b0;
    done_o       = 1'b0;
    counter_type = '0;
    data_in      = '0;
    case (state)
      WRITE:   write_param = 1'b1;
      RECONF:  reconfig    = 1'b1;
      AREST:   areset      = 1'b1;
      DONE:    done_o      = 1'b1;
      default: ;
    endcase
    if ((state == WRITE) || (state == WAIT_WR)) begin
      counter_type = 4'(CNT_TYPE_BASE) + 4'(cur_idx);
      data_in      = data_q[int'(cur_idx) * DATA_W +: DATA_W];
    end
  end

  assign bus.cfg_ready          = cfg_ready;
  assign bus.rcfg_write_param   = write_param;
  assign bus.rcfg_counter_type  = counter_type;
  assign bus.rcfg_counter_param = 3'(CNT_PARAM);
  assign bus.rcfg_data_in       = data_in;
  assign bus.rcfg_reconfig      = reconfig;
  assign bus.pll_areset         = areset;
  assign bus.done               = done_o;
  assign bus.error              = error_q;
  assign bus.state_test         = state;
endmodule
